// File: rtl/puf_soc_scan_ctrl.sv
// Scan sequencer for the PUF response mux: visits each enabled instance in ascending
// order, waits the settle time, samples into a packed vector, then hands it off valid/ready.
module puf_soc_scan_ctrl #(
    parameter int N_BIT      = 1,
    parameter int MUX_SZ     = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [MUX_SZ-1:0]         i_en_mask,
    input  logic [N_BIT-1:0]          i_mux_data,
    output logic [$clog2(MUX_SZ)-1:0] o_sel_mux,
    output logic                      o_busy,
    output logic [MUX_SZ*N_BIT-1:0]   o_resp,
    output logic                      o_valid,
    input  logic                      i_ready
);
    localparam int SW = $clog2(MUX_SZ);
    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t                    r_state, w_state_nxt;
    logic [SW-1:0]             r_sel;
    logic [7:0]                r_cnt;
    logic [MUX_SZ-1:0]         r_mask;
    logic [MUX_SZ*N_BIT-1:0]   r_resp;

    logic [SW-1:0]             w_first_idx;
    logic [SW-1:0]             w_nxt_idx;
    logic                      w_nxt_vld;
    int                        w_sel_int;

    // Priority searches: descending loops so the lowest qualifying index wins.
    always_comb begin
        w_first_idx = '0;
        w_nxt_idx   = '0;
        w_nxt_vld   = 1'b0;
        w_sel_int   = int'(r_sel);
        for (int k = MUX_SZ - 1; k >= 0; k--) begin
            if (i_en_mask[k]) w_first_idx = SW'(k);
            if (r_mask[k] && (k > w_sel_int)) begin
                w_nxt_idx = SW'(k);
                w_nxt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = (i_en_mask == '0) ? DONE : SETTLE;
            SETTLE:  if (r_cnt == 8'd0) w_state_nxt = SAMPLE;
            SAMPLE:  w_state_nxt = w_nxt_vld ? SETTLE : DONE;
            DONE:    if (i_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel  <= '0;
            r_cnt  <= 8'd0;
            r_mask <= '0;
            r_resp <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_mask <= i_en_mask;
                    r_resp <= '0;
                    if (i_en_mask != '0) begin
                        r_sel <= w_first_idx;
                        r_cnt <= CNT_LOAD;
                    end
                end
                SETTLE: if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
                SAMPLE: begin
                    for (int k = 0; k < MUX_SZ; k++)
                        if (r_sel == SW'(k)) r_resp[k*N_BIT +: N_BIT] <= i_mux_data;
                    // On the last enabled slot the select is left on it.
                    if (w_nxt_vld) begin
                        r_sel <= w_nxt_idx;
                        r_cnt <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sel_mux = r_sel;
    assign o_resp    = r_resp;
    assign o_busy    = (r_state != IDLE);
    assign o_valid   = (r_state == DONE);
endmodule

// File: tb/tb_puf_soc_scan_ctrl.sv
// Randomized bench for puf_soc_scan_ctrl: two instances (settle 4 and settle 1) checked
// against a model built from enabled-index lists, latency formula and masked patterns.
module tb_puf_soc_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start0 = 1'b0, ready0 = 1'b0;
    logic [15:0] mask0 = '0, pat0 = '0, resp0;
    logic [3:0]  sel0;
    logic        busy0, valid0;
    logic [0:0]  data0;

    logic        start1 = 1'b0, ready1 = 1'b0;
    logic [15:0] mask1 = '0, pat1 = '0, resp1;
    logic [3:0]  sel1;
    logic        busy1, valid1;
    logic [0:0]  data1;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign data0 = pat0[sel0];
    assign data1 = pat1[sel1];

    puf_soc_scan_ctrl #(.N_BIT(1), .MUX_SZ(16), .SETTLE_CYC(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_en_mask(mask0),
        .i_mux_data(data0), .o_sel_mux(sel0), .o_busy(busy0), .o_resp(resp0),
        .o_valid(valid0), .i_ready(ready0));

    puf_soc_scan_ctrl #(.N_BIT(1), .MUX_SZ(16), .SETTLE_CYC(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_en_mask(mask1),
        .i_mux_data(data1), .o_sel_mux(sel1), .o_busy(busy1), .o_resp(resp1),
        .o_valid(valid1), .i_ready(ready1));

    // One complete scan on instance `which`, checking select sequence, latency,
    // result, handshake hold and release. inject_at>0 pulses start and rewrites the mask then.
    task automatic run_scan(input int which, input logic [15:0] mask, input logic [15:0] pat,
                            input int inject_at, input int hold);
        int sc, lat, c, n;
        int idx[$];
        logic [15:0] exp_resp;
        logic v, b;
        logic [3:0] s;
        logic [15:0] r;
        sc = (which == 0) ? 4 : 1;
        idx = {};
        for (int k = 0; k < 16; k++) if (mask[k]) idx.push_back(k);
        n = idx.size();
        lat = n * (sc + 1);
        exp_resp = mask & pat;
        @(negedge clk);
        if (which == 0) begin mask0 = mask; pat0 = pat; start0 = 1'b1; end
        else            begin mask1 = mask; pat1 = pat; start1 = 1'b1; end
        @(posedge clk);
        c = 1;
        forever begin
            @(negedge clk);
            if (which == 0) begin
                start0 = (c == inject_at);
                if (c == inject_at) mask0 = 16'h0001;
                v = valid0; b = busy0; s = sel0; r = resp0;
            end else begin
                start1 = (c == inject_at);
                if (c == inject_at) mask1 = 16'h0001;
                v = valid1; b = busy1; s = sel1; r = resp1;
            end
            if (v) begin
                n_cmp++;
                if (c - 1 != lat) begin
                    n_fail++;
                    $display("FAIL latency: got %0d edges, want %0d (mask %h)", c - 1, lat, mask);
                end
                if (which == 0) ready0 = 1'b0; else ready1 = 1'b0;
                break;
            end
            n_cmp++;
            if (!b || (n > 0 && s !== 4'(idx[(c - 1) / (sc + 1)]))) begin
                n_fail++;
                $display("FAIL scan_step c=%0d: sel=%0d busy=%b, want sel=%0d busy=1",
                         c, s, b, (n > 0) ? idx[(c - 1) / (sc + 1)] : -1);
            end
            if (c > 400) begin
                n_fail++;
                $display("FAIL timeout: o_valid never rose (mask %h)", mask);
                return;
            end
            if (which == 0) ready0 = 1'($urandom); else ready1 = 1'($urandom);
            c++;
        end
        for (int h = 0; h <= hold; h++) begin
            if (which == 0) begin v = valid0; b = busy0; r = resp0; end
            else            begin v = valid1; b = busy1; r = resp1; end
            n_cmp++;
            if (v !== 1'b1 || b !== 1'b1 || r !== exp_resp) begin
                n_fail++;
                $display("FAIL done_hold h=%0d: valid=%b busy=%b resp=%h, want 1 1 %h",
                         h, v, b, r, exp_resp);
            end
            if (h < hold) @(negedge clk);
        end
        if (which == 0) ready0 = 1'b1; else ready1 = 1'b1;
        @(negedge clk);
        if (which == 0) begin ready0 = 1'b0; v = valid0; b = busy0; r = resp0; end
        else            begin ready1 = 1'b0; v = valid1; b = busy1; r = resp1; end
        n_cmp++;
        if (v !== 1'b0 || b !== 1'b0 || r !== exp_resp) begin
            n_fail++;
            $display("FAIL release: valid=%b busy=%b resp=%h, want 0 0 %h", v, b, r, exp_resp);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (sel0 !== 4'd0 || busy0 !== 1'b0 || valid0 !== 1'b0 || resp0 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: sel=%0d busy=%b valid=%b resp=%h, want all 0", sel0, busy0, valid0, resp0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_scan();
        run_scan(0, 16'hFFFF, 16'hAAAA, 0, 3);
    endtask

    task automatic test_sparse();
        run_scan(0, 16'h8011, 16'hFFFF, 0, 2);
    endtask

    task automatic test_empty();
        run_scan(0, 16'h0000, 16'hFFFF, 0, 10);
    endtask

    task automatic test_ignored_start();
        run_scan(0, 16'h00F0, 16'hFFFF, 7, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL no_requeue: busy=%b, want 0", busy0);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        @(negedge clk);
        mask0 = 16'h80FF; pat0 = 16'hFFFF; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        guard = 0;
        while (sel0 != 4'd7 && guard < 200) begin @(negedge clk); guard++; end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sel0 !== 4'd0 || busy0 !== 1'b0 || valid0 !== 1'b0 || resp0 !== 16'd0 || guard >= 200) begin
            n_fail++;
            $display("FAIL async_reset: sel=%0d busy=%b valid=%b resp=%h guard=%0d, want 0s",
                     sel0, busy0, valid0, resp0, guard);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(0, 16'h0C20, 16'($urandom), 0, 1);
    endtask

    task automatic test_settle_boundary();
        run_scan(1, 16'h0003, 16'h0002, 0, 1);
        run_scan(1, 16'h0003, 16'h0001, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_scan(i % 2, 16'($urandom), 16'($urandom), 0, int'($urandom_range(0, 4)));
    endtask

    task automatic test_back_to_back();
        run_scan(0, 16'h0102, 16'hFFFF, 0, 0);
        run_scan(0, 16'h4000, 16'h4000, 0, 0);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse();
        test_empty();
        test_ignored_start();
        test_async_reset();
        test_settle_boundary();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
